// File: rtl/echo_mix.sv
// echo_mix: joins dry and delayed wet samples, attenuates wet, saturating add.
// Optional 2-entry elastic output buffer with registered readies: ECHO_MIX_SKID_EN.
module echo_mix #(
  parameter int width_p = 8,
  parameter int shift_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] dry_data_i,
  input  logic               dry_valid_i,
  output logic               dry_ready_o,
  input  logic [width_p-1:0] wet_data_i,
  input  logic               wet_valid_i,
  output logic               wet_ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic               clip_o,
  input  logic               ready_i
);

  localparam logic [width_p-1:0] max_lp =
    {1'b0, {(width_p-1){1'b1}}};
  localparam logic [width_p-1:0] min_lp =
    {1'b1, {(width_p-1){1'b0}}};

  logic signed [width_p:0] dry_x;
  logic signed [width_p:0] wet_x;
  logic signed [width_p:0] sum;
  logic [width_p-1:0]      res;
  logic                    res_clip;
  logic                    ovf;
  logic                    space;
  logic                    fire;
  logic                    xfer;

  logic               valid_q;
  logic [width_p-1:0] data_q;
  logic               clip_q;

  assign dry_x = {dry_data_i[width_p-1], dry_data_i};
  assign wet_x = {wet_data_i[width_p-1], wet_data_i};
  assign sum   = dry_x + (wet_x >>> shift_p);
  // sign of the wide sum disagrees with the narrow sign bit on overflow
  assign ovf   = sum[width_p] ^ sum[width_p-1];

  always_comb begin
    res      = sum[width_p-1:0];
    res_clip = 1'b0;
    if (ovf) begin
      res      = sum[width_p] ? min_lp : max_lp;
      res_clip = 1'b1;
    end
  end

  assign dry_ready_o = space & wet_valid_i;
  assign wet_ready_o = space & dry_valid_i;
  assign fire        = dry_valid_i & wet_valid_i & space;
  assign xfer        = valid_q & ready_i;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign clip_o  = clip_q;

`ifdef ECHO_MIX_SKID_EN

  logic               skid_v_q;
  logic [width_p-1:0] skid_d_q;
  logic               skid_c_q;

  // skid slot empty means at most one entry held: readies are flop-only
  assign space = ~skid_v_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      clip_q   <= 1'b0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      skid_c_q <= 1'b0;
    end else if (!valid_q || xfer) begin
      if (skid_v_q) begin
        valid_q  <= 1'b1;
        data_q   <= skid_d_q;
        clip_q   <= skid_c_q;
        skid_v_q <= 1'b0;
      end else if (fire) begin
        valid_q <= 1'b1;
        data_q  <= res;
        clip_q  <= res_clip;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (fire) begin
      skid_v_q <= 1'b1;
      skid_d_q <= res;
      skid_c_q <= res_clip;
    end
  end

`else

  assign space = ~valid_q | ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      clip_q  <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
      data_q  <= res;
      clip_q  <= res_clip;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_echo_mix.sv
// tb_echo_mix: directed checks of join, mix, saturation, stall and reset.
// Inputs driven and outputs sampled at negedge; DUT updates on posedge.
module tb_echo_mix;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] dry_data_i;
  logic       dry_valid_i;
  logic       dry_ready_o;
  logic [7:0] wet_data_i;
  logic       wet_valid_i;
  logic       wet_ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       clip_o;
  logic       ready_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  echo_mix #(.width_p(8), .shift_p(1)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .dry_data_i  (dry_data_i),
    .dry_valid_i (dry_valid_i),
    .dry_ready_o (dry_ready_o),
    .wet_data_i  (wet_data_i),
    .wet_valid_i (wet_valid_i),
    .wet_ready_o (wet_ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .clip_o      (clip_o),
    .ready_i     (ready_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic mix(input logic [7:0] d, input logic [7:0] w,
                     input logic [7:0] ed, input logic ec,
                     input string tag);
    dry_data_i = d;
    wet_data_i = w;
    cyc();
    chk({tag, "_v"}, 32'(valid_o), 32'd1);
    chk({tag, "_d"}, 32'(data_o), 32'(ed));
    chk({tag, "_c"}, 32'(clip_o), 32'(ec));
  endtask

  int idx;
  int outs;
  int xfers;
  logic [7:0] held;
  int absorbed_exp;

  initial begin
`ifdef ECHO_MIX_SKID_EN
    absorbed_exp = 2;
`else
    absorbed_exp = 1;
`endif
    reset_i = 1'b1;
    dry_valid_i = 1'b1;
    wet_valid_i = 1'b1;
    dry_data_i = 8'd50;
    wet_data_i = 8'd60;
    ready_i = 1'b1;
    @(negedge clk_i);
    cyc();
    chk("rst_v", 32'(valid_o), 32'd0);
    chk("rst_d", 32'(data_o), 32'd0);
    chk("rst_c", 32'(clip_o), 32'd0);

    // basic mix and saturation, back-to-back fires
    reset_i = 1'b0;
    dry_data_i = 8'd10;
    wet_data_i = 8'd20;
    #1;
    chk("first_rdy", 32'(dry_ready_o & wet_ready_o), 32'd1);
    mix(8'd10, 8'd20, 8'd20, 1'b0, "mix_10_20");
    mix(8'h00, 8'hFD, 8'hFE, 1'b0, "mix_0_m3");
    mix(8'd100, 8'd100, 8'h7F, 1'b1, "sat_pos");
    mix(8'h80, 8'h80, 8'h80, 1'b1, "sat_neg");
    mix(8'd127, 8'd0, 8'h7F, 1'b0, "max_noclip");
    dry_valid_i = 1'b0;
    wet_valid_i = 1'b0;
    cyc();
    chk("idle_v", 32'(valid_o), 32'd0);
    chk("idle_d", 32'(data_o), 32'h7F);

    // join stall: dry alone is never accepted
    dry_valid_i = 1'b1;
    dry_data_i = 8'd5;
    wet_data_i = 8'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_dry_rdy", 32'(dry_ready_o), 32'd0);
      chk("stall_wet_rdy", 32'(wet_ready_o), 32'd1);
      cyc();
      chk("stall_v", 32'(valid_o), 32'd0);
    end
    wet_valid_i = 1'b1;
    #1;
    chk("join_rdy", 32'(dry_ready_o), 32'd1);
    cyc();
    chk("join_v", 32'(valid_o), 32'd1);
    chk("join_d", 32'(data_o), 32'd7);
    dry_valid_i = 1'b0;
    wet_valid_i = 1'b0;
    cyc();
    chk("join_once", 32'(valid_o), 32'd0);

    // backpressure: 8 samples dry=k+1, wet=2(k+1) -> 2(k+1)
    idx = 0;
    outs = 0;
    held = '0;
    for (int c = 0; c < 40 && outs < 8; c++) begin
      dry_valid_i = (idx < 8);
      wet_valid_i = (idx < 8);
      dry_data_i = 8'(idx + 1);
      wet_data_i = 8'(2 * (idx + 1));
      ready_i = !(c >= 2 && c <= 5);
      #1;
      if (valid_o && ready_i) begin
        chk("bp_data", 32'(data_o), 32'(2 * (outs + 1)));
        chk("bp_clip", 32'(clip_o), 32'd0);
        outs++;
      end
      if (c == 2) held = data_o;
      if (c > 2 && c <= 5) begin
        chk("bp_hold_v", 32'(valid_o), 32'd1);
        chk("bp_hold_d", 32'(data_o), 32'(held));
      end
      if (dry_valid_i && wet_valid_i && dry_ready_o && wet_ready_o)
        idx++;
      if (c == 5)
        chk("bp_absorbed", 32'(idx - outs), 32'(absorbed_exp));
      cyc();
    end
    chk("bp_count", 32'(outs), 32'd8);
    chk("bp_consumed", 32'(idx), 32'd8);
    chk("bp_drain_v", 32'(valid_o), 32'd0);

    // mid-stream reset discards a held sample
    dry_valid_i = 1'b1;
    wet_valid_i = 1'b1;
    dry_data_i = 8'd1;
    wet_data_i = 8'd2;
    ready_i = 1'b0;
    cyc();
    chk("mr_pre_v", 32'(valid_o), 32'd1);
    chk("mr_pre_d", 32'(data_o), 32'd2);
    dry_valid_i = 1'b0;
    wet_valid_i = 1'b0;
    reset_i = 1'b1;
    cyc();
    chk("mr_v", 32'(valid_o), 32'd0);
    chk("mr_d", 32'(data_o), 32'd0);
    reset_i = 1'b0;
    ready_i = 1'b1;
    xfers = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (valid_o && ready_i) xfers++;
      cyc();
    end
    chk("mr_no_xfer", 32'(xfers), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_mix.md
Name: echo_mix

Overview:
- Downstream consumer of the delay buffer in the echo/audio datapath.
- Joins two ready/valid sample streams:
  - dry: the undelayed sample.
  - wet: the delay-buffer output.
- Attenuates wet by an arithmetic right shift, adds it to dry with saturation, and emits the mixed sample on a registered ready/valid output with a per-sample clip flag.

Parameters:
- width_p, 8: sample width; all samples are signed two's complement.
- shift_p, 1: wet attenuation as an arithmetic right shift; legal range 0..width_p-1.

Ports:
- clk_i  input  1  clock; all state changes on posedge.
- reset_i  input  1  synchronous, active-high reset.
- dry_data_i  input  width_p  dry sample.
- dry_valid_i  input  1  dry sample valid.
- dry_ready_o  output  1  dry sample accepted when dry_valid_i & dry_ready_o.
- wet_data_i  input  width_p  delayed sample (from the delay buffer's data_o).
- wet_valid_i  input  1  delayed sample valid.
- wet_ready_o  output  1  drives the delay buffer's ready_i.
- valid_o  output  1  mixed sample valid.
- data_o  output  width_p  mixed, saturated sample.
- clip_o  output  1  1 when the current data_o was saturated; qualified by valid_o.
- ready_i  input  1  downstream ready.

Behaviour:
- Reset (reset_i=1 at posedge):
  - valid_o=0, data_o=0, clip_o=0.
  - All buffered entries are discarded, including when reset occurs mid-stream.
  - Reset has priority over every other event in the same cycle.
- space:
  - Base build: space = ~valid_o | ready_i.
  - Optional build: see Optional Feature.
- Join handshake:
  - dry_ready_o = space & wet_valid_i.
  - wet_ready_o = space & dry_valid_i.
  - fire = dry_valid_i & wet_valid_i & space; both inputs are consumed together on fire, never one alone.
  - A lone valid stream is held indefinitely with its ready at 0; its data is not sampled.
  - Neither ready depends combinationally on its own stream's valid.
- Arithmetic:
  - Computed at width_p+1 bits: sum = sext(dry) + (sext(wet) >>> shift_p).
  - The shift is arithmetic (rounds toward -inf).
  - Result above 2^(width_p-1)-1 becomes that maximum with clip=1.
  - Result below -2^(width_p-1) becomes that minimum with clip=1.
  - Otherwise sum[width_p-1:0] with clip=0.
- Latency:
  - The result appears on data_o/clip_o with valid_o=1 on the cycle after fire.
  - Throughput is one sample per cycle while ready_i=1 and both inputs are valid.
- Output hold:
  - While valid_o & ~ready_i, data_o and clip_o remain stable and valid_o stays 1.
  - Output transfer occurs on valid_o & ready_i.
  - A simultaneous output transfer and fire loads the new result in the same edge, with no bubble.
- Ordering: samples exit in input order; no loss, no duplication.
- Idle: when no fire occurs and the output transfers, valid_o goes to 0 on the next cycle; data_o retains its last value.

Optional Feature:
- Macro ECHO_MIX_SKID_EN.
- Defined:
  - Adds a second output entry (2-entry elastic buffer); the readies are driven from registered state.
  - space = "fewer than 2 entries occupied, or 1 occupied and not becoming full" is computed from registers only.
  - No combinational path from ready_i to dry_ready_o or wet_ready_o.
  - Up to 2 results are absorbed during backpressure.
  - Latency stays 1 cycle when the buffer is empty.
- Undefined: single output register as described above; a combinational path ready_i -> input readies exists.

Test Plan:
- Reset: assert reset_i 2 cycles with dry/wet valid=1 -> valid_o=0, data_o=0, clip_o=0. After release, the first result appears 1 cycle after the first fire.
- Basic mix (width_p=8, shift_p=1):
  - dry=10, wet=20, ready_i=1 -> next cycle data_o=20, clip_o=0.
  - Then dry=0, wet=-3 -> data_o=-2 (0xFE).
- Saturation:
  - dry=100, wet=100 -> data_o=127 (0x7F), clip_o=1.
  - dry=-128, wet=-128 -> data_o=-128 (0x80), clip_o=1.
  - dry=127, wet=0 -> data_o=127, clip_o=0.
- Join stall:
  - dry_valid_i=1 with wet_valid_i=0 for 5 cycles -> dry_ready_o=0 throughout, valid_o stays 0.
  - Then raise wet_valid_i for 1 cycle -> exactly one fire and one output sample.
- Backpressure:
  - Stream 8 samples with both valids held 1 and ready_i=0 for cycles 2..5 -> data_o stable while held.
  - Inputs consumed during the stall: 1 in base build, 2 with ECHO_MIX_SKID_EN.
  - After ready_i returns to 1, all 8 results exit in order, 1 per cycle, none lost or duplicated.
- Mid-stream reset: pulse reset_i for 1 cycle while valid_o=1 and ready_i=0 -> next cycle valid_o=0, and the held sample is never transferred.
